// File: rtl/slip_term_pkg.sv
// Shared types and sizes for the six-term AND qualify source sequencer.
package slip_term_pkg;

  localparam int N_TERMS = 6;  // must match the downstream AND6 decode width
  localparam int STEP_W  = 4;  // StepLen width (gap between raises, minus 1)
  localparam int HOLD_W  = 8;  // HoldLen width (all-high window length)

  typedef logic [N_TERMS-1:0] term_vec_t;

  typedef enum logic [2:0] {
    IDLE,
    RAMP,
    HOLD,
    FALL,
    DONE
  } state_t;

  // A zero-length window would never let the decode fire, so 0 means 1.
  function automatic logic [HOLD_W-1:0] norm_hold(input logic [HOLD_W-1:0] len);
    return (len == '0) ? HOLD_W'(1) : len;
  endfunction

endpackage

// File: rtl/slip_and6_term_drv_if.sv
// Control/status bundle between the register bank (master) and the term driver (slave).
interface slip_and6_term_drv_if;
  import slip_term_pkg::*;

  logic              Req;
  logic              Abort;
  logic [STEP_W-1:0] StepLen;
  logic [HOLD_W-1:0] HoldLen;
  term_vec_t         Terms;
  logic              AllHigh;
  logic              Busy;
  logic              Ack;
  logic              Aborted;

  modport master (
    output Req, Abort, StepLen, HoldLen,
    input  Terms, AllHigh, Busy, Ack, Aborted
  );

  modport slave (
    input  Req, Abort, StepLen, HoldLen,
    output Terms, AllHigh, Busy, Ack, Aborted
  );

endinterface

// File: rtl/slip_dn_counter.sv
// Loadable down-counter with zero flag; stops at zero instead of wrapping.
module slip_dn_counter #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic [W-1:0] o_count,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  // Load has priority over decrement; holding at zero keeps a stray decrement harmless.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule

// File: rtl/slip_and6_term_drv.sv
// Term driver: raises six AND terms in order, holds the all-high window, then drops them.
module slip_and6_term_drv
  import slip_term_pkg::*;
(
  input  logic                 MasterClock,
  input  logic                 ResetL,
  slip_and6_term_drv_if.slave  bus
);

  state_t            r_state;
  term_vec_t         r_terms;
  logic              r_all_high;
  logic              r_busy;
  logic              r_ack;
  logic              r_aborted;
  logic [STEP_W-1:0] r_step_len;

  logic              w_accept;
  logic              w_step_load;
  logic [STEP_W-1:0] w_step_val;
  logic              w_step_zero;
  logic [STEP_W-1:0] w_step_count_unused;
  logic [HOLD_W-1:0] w_hold_count;
  logic              w_hold_zero;
  logic              w_hold_last;
  term_vec_t         w_terms_shift;

  // A start needs Req in IDLE without a simultaneous Abort.
  assign w_accept      = (r_state == IDLE) && bus.Req && !bus.Abort;
  // Terms are a thermometer: shift a one in from the A end.
  assign w_terms_shift = {r_terms[N_TERMS-2:0], 1'b1};

  // Step counter: loaded from the port on accept, reloaded from the captured length on each raise.
  assign w_step_load = w_accept || ((r_state == RAMP) && w_step_zero);
  assign w_step_val  = (r_state == IDLE) ? bus.StepLen : r_step_len;

  slip_dn_counter #(.W(STEP_W)) u_step_cnt (
    .i_clk      (MasterClock),
    .i_rst_n    (ResetL),
    .i_load     (w_step_load),
    .i_load_val (w_step_val),
    .i_dec      (r_state == RAMP),
    .o_count    (w_step_count_unused),
    .o_zero     (w_step_zero)
  );

  // Hold counter: loaded on accept and left untouched through RAMP, so it
  // already holds the window length when HOLD is entered.
  slip_dn_counter #(.W(HOLD_W)) u_hold_cnt (
    .i_clk      (MasterClock),
    .i_rst_n    (ResetL),
    .i_load     (w_accept),
    .i_load_val (norm_hold(bus.HoldLen)),
    .i_dec      (r_state == HOLD),
    .o_count    (w_hold_count),
    .o_zero     (w_hold_zero)
  );

  // The zero check only guards against a count that should never reach HOLD.
  assign w_hold_last = (w_hold_count == HOLD_W'(1)) || w_hold_zero;

  // Sequencer: every output is registered here so the decode sees clean edges.
  always_ff @(posedge MasterClock or negedge ResetL) begin
    if (!ResetL) begin
      r_state    <= IDLE;
      r_terms    <= '0;
      r_all_high <= 1'b0;
      r_busy     <= 1'b0;
      r_ack      <= 1'b0;
      r_aborted  <= 1'b0;
      r_step_len <= '0;
    end else begin
      r_ack     <= 1'b0;
      r_aborted <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state    <= RAMP;
            r_terms    <= term_vec_t'(1);
            r_step_len <= bus.StepLen;
            r_busy     <= 1'b1;
          end
        end
        RAMP: begin
          if (bus.Abort) begin
            r_state    <= DONE;
            r_terms    <= '0;
            r_all_high <= 1'b0;
            r_aborted  <= 1'b1;
          end else if (w_step_zero) begin
            r_terms    <= w_terms_shift;
            r_all_high <= &w_terms_shift;
            if (r_terms[N_TERMS-2]) begin
              r_state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (bus.Abort) begin
            r_state    <= DONE;
            r_terms    <= '0;
            r_all_high <= 1'b0;
            r_aborted  <= 1'b1;
          end else if (w_hold_last) begin
            r_state    <= FALL;
            r_terms    <= '0;
            r_all_high <= 1'b0;
          end
        end
        FALL: begin
          r_state <= DONE;
          r_ack   <= 1'b1;
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state    <= IDLE;
          r_terms    <= '0;
          r_all_high <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Terms   = r_terms;
  assign bus.AllHigh = r_all_high;
  assign bus.Busy    = r_busy;
  assign bus.Ack     = r_ack;
  assign bus.Aborted = r_aborted;

endmodule

// File: tb/tb_slip_and6_term_drv.sv
// Self-checking bench: directed scenarios plus randomized traffic against a timeline model.
module tb_slip_and6_term_drv;
  import slip_term_pkg::*;

  logic clk   = 1'b0;
  logic rst_l = 1'b1;
  always #5 clk = ~clk;

  slip_and6_term_drv_if bus();

  slip_and6_term_drv dut (
    .MasterClock (clk),
    .ResetL      (rst_l),
    .bus         (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A request is described by its accept time: cycle k after the accept edge.
  // Ramp: term count = 1 + (k-1)/(s+1); all-high from k = 5(s+1)+1 for h cycles;
  // then one zero cycle, then the completion cycle, then idle.
  int m_active = 0;
  int m_k, m_s, m_h, m_done_k, m_abt;

  initial forever begin
    @(posedge clk or negedge rst_l);
    if (!rst_l) begin
      m_active = 0;
    end else if (m_active == 0) begin
      if (bus.Req && !bus.Abort) begin
        m_active = 1;
        m_k      = 1;
        m_s      = int'(bus.StepLen);
        m_h      = (bus.HoldLen == 0) ? 1 : int'(bus.HoldLen);
        m_abt    = 0;
        m_done_k = 5 * (m_s + 1) + 1 + m_h + 1;
      end
    end else if (m_k == m_done_k) begin
      m_active = 0;
    end else begin
      if (m_abt == 0 && m_k < 5 * (m_s + 1) + 1 + m_h && bus.Abort) begin
        m_abt    = 1;
        m_done_k = m_k + 1;
      end
      m_k++;
    end
  end

  // Expected {Terms, AllHigh, Busy, Ack, Aborted}.
  function automatic logic [9:0] model_exp();
    logic [5:0] t;
    int r, n;
    if (m_active == 0) return 10'd0;
    r = 5 * (m_s + 1) + 1;
    if (m_k == m_done_k) return {6'd0, 1'b0, 1'b1, (m_abt == 0), (m_abt != 0)};
    if (m_k >= r + m_h)  t = 6'd0;
    else if (m_k >= r)   t = 6'h3F;
    else begin
      n = 1 + (m_k - 1) / (m_s + 1);
      t = 6'((1 << n) - 1);
    end
    return {t, (t == 6'h3F), 1'b1, 1'b0, 1'b0};
  endfunction

  // Single compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("cycle_model", {22'd0, bus.Terms, bus.AllHigh, bus.Busy, bus.Ack, bus.Aborted},
        {22'd0, model_exp()});
  end

  // One line per completed transaction.
  always @(negedge clk) begin
    if (bus.Ack)     $display("txn: sequence completed at t=%0t", $time);
    if (bus.Aborted) $display("txn: sequence aborted at t=%0t", $time);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic run_until_idle(input string name, input int budget,
                                output int n_ah, output int n_ack, output int n_abt);
    int c;
    n_ah = 0; n_ack = 0; n_abt = 0; c = 0;
    while (bus.Busy && c < budget) begin
      tick();
      c++;
      n_ah  += int'(bus.AllHigh);
      n_ack += int'(bus.Ack);
      n_abt += int'(bus.Aborted);
    end
    chk({name, "_idle"}, {31'd0, bus.Busy}, 32'd0);
  endtask

  logic [5:0] lit_terms [11];
  logic       lit_ah    [11];
  logic       lit_ack   [11];
  logic       lit_busy  [11];

  initial begin
    int n_ah, n_ack, n_abt, c, z;
    lit_terms = '{6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3F, 6'h3F, 6'h3F, 6'h00, 6'h00, 6'h00};
    lit_ah    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    lit_ack   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    lit_busy  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    bus.Req = 1'b0; bus.Abort = 1'b0; bus.StepLen = '0; bus.HoldLen = '0;

    // Reset held 3 cycles with Req high, then release: start on the first edge.
    #1 rst_l = 1'b0;
    bus.Req = 1'b1; bus.StepLen = 4'd0; bus.HoldLen = 8'd3;
    repeat (3) tick();
    chk("reset_terms", {26'd0, bus.Terms}, 32'd0);
    chk("reset_busy",  {31'd0, bus.Busy},  32'd0);
    chk("reset_ack",   {31'd0, bus.Ack},   32'd0);
    @(negedge clk) rst_l = 1'b1;

    // StepLen=0, HoldLen=3: literal cycle-by-cycle timeline.
    for (int i = 0; i < 11; i++) begin
      tick();
      bus.Req = 1'b0;
      chk($sformatf("t1_terms_c%0d", i + 1), {26'd0, bus.Terms},   {26'd0, lit_terms[i]});
      chk($sformatf("t1_ah_c%0d",    i + 1), {31'd0, bus.AllHigh}, {31'd0, lit_ah[i]});
      chk($sformatf("t1_ack_c%0d",   i + 1), {31'd0, bus.Ack},     {31'd0, lit_ack[i]});
      chk($sformatf("t1_busy_c%0d",  i + 1), {31'd0, bus.Busy},    {31'd0, lit_busy[i]});
    end
    $display("txn: directed StepLen=0 HoldLen=3 done");

    // StepLen=2, HoldLen=0: 3 cycles per raise, 1-cycle window, one Ack.
    tick();
    bus.Req = 1'b1; bus.StepLen = 4'd2; bus.HoldLen = 8'd0;
    tick();
    bus.Req = 1'b0;
    chk("t2_c1", {26'd0, bus.Terms}, 32'h01);
    tick(); tick();
    chk("t2_c3", {26'd0, bus.Terms}, 32'h01);
    tick();
    chk("t2_c4", {26'd0, bus.Terms}, 32'h03);
    run_until_idle("t2", 60, n_ah, n_ack, n_abt);
    chk("t2_window", n_ah,  32'd1);
    chk("t2_acks",   n_ack, 32'd1);

    // Abort when Terms=07.
    tick();
    bus.Req = 1'b1; bus.StepLen = 4'd1; bus.HoldLen = 8'd5;
    tick();
    bus.Req = 1'b0;
    c = 0;
    while (bus.Terms != 6'h07 && c < 30) begin tick(); c++; end
    chk("t3_reach07", {26'd0, bus.Terms}, 32'h07);
    bus.Abort = 1'b1;
    tick();
    bus.Abort = 1'b0;
    chk("t3_terms",   {26'd0, bus.Terms},   32'd0);
    chk("t3_aborted", {31'd0, bus.Aborted}, 32'd1);
    chk("t3_ack",     {31'd0, bus.Ack},     32'd0);
    chk("t3_busy",    {31'd0, bus.Busy},    32'd1);
    tick();
    chk("t3_abt_once", {31'd0, bus.Aborted}, 32'd0);
    chk("t3_busy_low", {31'd0, bus.Busy},    32'd0);

    // Req during HOLD and during DONE is ignored.
    tick();
    bus.Req = 1'b1; bus.StepLen = 4'd0; bus.HoldLen = 8'd4;
    tick();
    bus.Req = 1'b0;
    repeat (6) tick();                       // cycle 7: HOLD
    chk("t4_hold", {31'd0, bus.AllHigh}, 32'd1);
    bus.Req = 1'b1;
    tick();
    bus.Req = 1'b0;
    repeat (3) tick();                       // cycle 11: DONE
    chk("t4_ack", {31'd0, bus.Ack}, 32'd1);
    bus.Req = 1'b1;
    tick();
    bus.Req = 1'b0;
    chk("t4_idle", {31'd0, bus.Busy}, 32'd0);
    z = 0;
    repeat (10) begin tick(); z += int'(bus.Busy); end
    chk("t4_no_restart", z, 32'd0);

    // Req held high: back-to-back, two zero cycles (DONE, IDLE) between runs.
    bus.Req = 1'b1; bus.StepLen = 4'd0; bus.HoldLen = 8'd2;
    c = 0;
    while (!bus.Ack && c < 60) begin tick(); c++; end
    chk("t5_first_ack", {31'd0, bus.Ack}, 32'd1);
    z = 0; c = 0;
    while (bus.Terms == 6'h00 && c < 10) begin z++; tick(); c++; end
    chk("t5_gap",     z, 32'd2);
    chk("t5_restart", {26'd0, bus.Terms}, 32'h01);
    bus.Req = 1'b0;
    run_until_idle("t5", 60, n_ah, n_ack, n_abt);
    chk("t5_second_ack", n_ack, 32'd1);

    // Asynchronous reset mid-HOLD: terms drop with no clock edge.
    tick();
    bus.Req = 1'b1; bus.StepLen = 4'd0; bus.HoldLen = 8'd8;
    tick();
    bus.Req = 1'b0;
    repeat (7) tick();                       // cycle 8: HOLD
    chk("t6_hold", {26'd0, bus.Terms}, 32'h3F);
    #1 rst_l = 1'b0;
    #1;
    chk("t6_terms",   {26'd0, bus.Terms},   32'd0);
    chk("t6_allhigh", {31'd0, bus.AllHigh}, 32'd0);
    chk("t6_busy",    {31'd0, bus.Busy},    32'd0);
    tick(); tick();
    @(negedge clk) rst_l = 1'b1;
    z = 0;
    repeat (20) begin tick(); z += int'(bus.Ack) + int'(bus.Aborted) + int'(bus.Busy); end
    chk("t6_quiet", z, 32'd0);

    // Randomized traffic, checked every cycle by the model.
    for (int i = 0; i < 4000; i++) begin
      int r;
      tick();
      bus.Req   = ($urandom_range(0, 9) < 3);
      bus.Abort = ($urandom_range(0, 59) == 0);
      r = int'($urandom_range(0, 9));
      if (r < 6)      bus.StepLen = 4'($urandom_range(0, 2));
      else if (r < 9) bus.StepLen = 4'($urandom_range(0, 15));
      else            bus.StepLen = 4'd15;
      r = int'($urandom_range(0, 9));
      if (r < 2)      bus.HoldLen = 8'd0;
      else if (r < 9) bus.HoldLen = 8'($urandom_range(1, 6));
      else            bus.HoldLen = 8'($urandom_range(0, 255));
    end
    bus.Req = 1'b0; bus.Abort = 1'b0;
    run_until_idle("rand", 600, n_ah, n_ack, n_abt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
